// File: rtl/atm_pkg.sv
// Shared types and constants for the ATM transaction engine slice.
package atm_pkg;
  localparam int ACCT_W = 4;
  localparam int BAL_W  = 10;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {SEL_EXIT = 2'd0, SEL_BAL = 2'd1, SEL_WDR = 2'd2, SEL_XFER = 2'd3} sel_e;
  typedef enum logic [1:0] {RES_OK = 2'd0, RES_FUNDS = 2'd1, RES_OVF = 2'd2, RES_SAME = 2'd3} res_e;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_READ = 2'd1, ST_EXEC = 2'd2, ST_RESP = 2'd3} state_e;

  typedef struct packed {
    sel_e              sel;
    logic [ACCT_W-1:0] acct_s;
    logic [ACCT_W-1:0] acct_d;
    logic [BAL_W-1:0]  amount;
  } req_t;
endpackage

// File: rtl/atm_txn_engine_if.sv
// Request/response bus between the ATM initiator and the transaction engine.
interface atm_txn_engine_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] Select;
  logic [3:0] AccountNumber_s;
  logic [3:0] AccountNumber_d;
  logic [9:0] Amount;
  logic       resp_valid;
  logic       resp_ready;
  logic [9:0] Balance;
  logic [1:0] result;
  logic [7:0] txn_count;

  modport master (
    output req_valid, Select, AccountNumber_s, AccountNumber_d, Amount, resp_ready,
    input  req_ready, resp_valid, Balance, result, txn_count
  );
  modport slave (
    input  req_valid, Select, AccountNumber_s, AccountNumber_d, Amount, resp_ready,
    output req_ready, resp_valid, Balance, result, txn_count
  );
endinterface

// File: rtl/atm_balance_rf.sv
// Account balance register file: two async read ports, two write ports.
module atm_balance_rf
  import atm_pkg::*;
#(
  parameter logic [BAL_W-1:0] INIT_BALANCE = 10'd100,
  parameter int               NUM_ACCT     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ACCT_W-1:0] ra_s,
  input  logic [ACCT_W-1:0] ra_d,
  output logic [BAL_W-1:0]  rd_s,
  output logic [BAL_W-1:0]  rd_d,
  input  logic              we_s,
  input  logic [ACCT_W-1:0] wa_s,
  input  logic [BAL_W-1:0]  wd_s,
  input  logic              we_d,
  input  logic [ACCT_W-1:0] wa_d,
  input  logic [BAL_W-1:0]  wd_d
);
  logic [NUM_ACCT-1:0][BAL_W-1:0] bal_q;

  assign rd_s = bal_q[ra_s];
  assign rd_d = bal_q[ra_d];

  // Callers never write both ports to the same account in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bal_q <= {NUM_ACCT{INIT_BALANCE}};
    end else begin
      if (we_s) bal_q[wa_s] <= wd_s;
      if (we_d) bal_q[wa_d] <= wd_d;
    end
  end
endmodule

// File: rtl/ten_bit_adder.sv
// 10-bit unsigned adder with carry-out; carry marks a sum that does not fit.
module ten_bit_adder (
  input  logic [9:0] a,
  input  logic [9:0] b,
  output logic [9:0] sum,
  output logic       cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b};
endmodule

// File: rtl/ten_bit_subtractor.sv
// 10-bit unsigned subtractor; borrow is set when b > a.
module ten_bit_subtractor (
  input  logic [9:0] a,
  input  logic [9:0] b,
  output logic [9:0] diff,
  output logic       borrow
);
  assign {borrow, diff} = {1'b0, a} - {1'b0, b};
endmodule

// File: rtl/atm_txn_engine.sv
// ATM transaction responder: IDLE -> READ -> EXEC -> RESP per request.
// Optional macro ATM_TXN_COUNT_EN builds a saturating committed-write counter.
module atm_txn_engine
  import atm_pkg::*;
#(
  parameter int INIT_BALANCE = 100,
  parameter int NUM_ACCT     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  atm_txn_engine_if.slave  bus
);
  state_e           state, nstate;
  req_t             req_q;
  logic [BAL_W-1:0] bal_s_q, bal_d_q, rd_s, rd_d;
  logic [BAL_W-1:0] bal_q, exec_bal;
  res_e             res_q, exec_res;
  logic [BAL_W-1:0] diff, sum;
  logic             borrow, cout;
  logic             wr_s, wr_d;

  atm_balance_rf #(.INIT_BALANCE(BAL_W'(INIT_BALANCE)), .NUM_ACCT(NUM_ACCT)) u_rf (
    .clk, .rst_n,
    .ra_s(req_q.acct_s), .ra_d(req_q.acct_d), .rd_s, .rd_d,
    .we_s(wr_s), .wa_s(req_q.acct_s), .wd_s(diff),
    .we_d(wr_d), .wa_d(req_q.acct_d), .wd_d(sum)
  );

  ten_bit_subtractor u_sub (.a(bal_s_q), .b(req_q.amount), .diff, .borrow);
  ten_bit_adder      u_add (.a(bal_d_q), .b(req_q.amount), .sum,  .cout);

  always_comb begin
    nstate = state;
    case (state)
      ST_IDLE: if (bus.req_valid) nstate = ST_READ;
      ST_READ: nstate = ST_EXEC;
      ST_EXEC: nstate = ST_RESP;
      ST_RESP: if (bus.resp_ready) nstate = ST_IDLE;
      default: nstate = ST_IDLE;
    endcase
  end

  // Error precedence for transfers: same account, then funds, then overflow.
  always_comb begin
    wr_s     = 1'b0;
    wr_d     = 1'b0;
    exec_bal = '0;
    exec_res = RES_OK;
    case (req_q.sel)
      SEL_EXIT: ;
      SEL_BAL:  exec_bal = bal_s_q;
      SEL_WDR: begin
        if (borrow) begin
          exec_res = RES_FUNDS;
          exec_bal = bal_s_q;
        end else begin
          wr_s     = (state == ST_EXEC);
          exec_bal = diff;
        end
      end
      SEL_XFER: begin
        exec_bal = bal_s_q;
        if (req_q.acct_s == req_q.acct_d) exec_res = RES_SAME;
        else if (borrow)                  exec_res = RES_FUNDS;
        else if (cout)                    exec_res = RES_OVF;
        else begin
          wr_s     = (state == ST_EXEC);
          wr_d     = (state == ST_EXEC);
          exec_bal = diff;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      req_q   <= '0;
      bal_s_q <= '0;
      bal_d_q <= '0;
      bal_q   <= '0;
      res_q   <= RES_OK;
    end else begin
      state <= nstate;
      if (state == ST_IDLE && bus.req_valid)
        req_q <= '{sel: sel_e'(bus.Select), acct_s: bus.AccountNumber_s,
                   acct_d: bus.AccountNumber_d, amount: bus.Amount};
      if (state == ST_READ) begin
        bal_s_q <= rd_s;
        bal_d_q <= rd_d;
      end
      if (state == ST_EXEC) begin
        bal_q <= exec_bal;
        res_q <= exec_res;
      end
    end
  end

  assign bus.req_ready  = (state == ST_IDLE);
  assign bus.resp_valid = (state == ST_RESP);
  assign bus.Balance    = bal_q;
  assign bus.result     = res_q;

`ifdef ATM_TXN_COUNT_EN
  logic [CNT_W-1:0] cnt_q;
  // wr_s is high exactly for committed withdraws and transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        cnt_q <= '0;
    else if (wr_s && cnt_q != '1)      cnt_q <= cnt_q + 1'b1;
  end
  assign bus.txn_count = cnt_q;
`else
  assign bus.txn_count = '0;
`endif
endmodule

// File: tb/tb_atm_txn_engine.sv
// Directed self-checking bench for atm_txn_engine.
module tb_atm_txn_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   exp_cnt = 0;

  atm_txn_engine_if bus ();
  atm_txn_engine #(.INIT_BALANCE(100), .NUM_ACCT(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cnt_exp();
`ifdef ATM_TXN_COUNT_EN
    return 32'(exp_cnt);
`else
    return 32'd0;
`endif
  endfunction

  // Issue one request from IDLE; optionally complete the response handshake.
  task automatic txn(input logic [1:0] sel, input logic [3:0] s, input logic [3:0] d,
                     input logic [9:0] amt, input logic rr,
                     output logic [9:0] bal, output logic [1:0] res, output int lat);
    bus.Select = sel; bus.AccountNumber_s = s; bus.AccountNumber_d = d; bus.Amount = amt;
    bus.resp_ready = rr;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (bus.resp_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (bus.resp_valid !== 1'b1) chk("resp_timeout", {31'd0, bus.resp_valid}, 32'd1);
    bal = bus.Balance;
    res = bus.result;
    if (rr) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic op(input string tag, input logic [1:0] sel, input logic [3:0] s,
                    input logic [3:0] d, input logic [9:0] amt,
                    input logic [9:0] ebal, input logic [1:0] eres);
    logic [9:0] b;
    logic [1:0] r;
    int         l;
    txn(sel, s, d, amt, 1'b1, b, r, l);
    chk({tag, "_bal"}, 32'(b), 32'(ebal));
    chk({tag, "_res"}, 32'(r), 32'(eres));
  endtask

  initial begin
    logic [9:0] b;
    logic [1:0] r;
    int         l;
    bus.req_valid = 1'b0; bus.resp_ready = 1'b0; bus.Select = 2'd0;
    bus.AccountNumber_s = 4'd0; bus.AccountNumber_d = 4'd0; bus.Amount = 10'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_balance", 32'(bus.Balance), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_txn_count", 32'(bus.txn_count), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Balance query and first-response latency
    txn(2'd1, 4'd5, 4'd0, 10'd0, 1'b1, b, r, l);
    chk("mojodi5_lat", 32'(l), 32'd3);
    chk("mojodi5_bal", 32'(b), 32'd100);
    chk("mojodi5_res", 32'(r), 32'd0);
    chk("idle_after_hs", {31'd0, bus.req_ready}, 32'd1);

    op("wdr2", 2'd2, 4'd2, 4'd0, 10'd30, 10'd70, 2'd0); exp_cnt++;
    op("bal2", 2'd1, 4'd2, 4'd0, 10'd0, 10'd70, 2'd0);
    chk("cnt_after_wdr", 32'(bus.txn_count), cnt_exp());

    op("wdr3_funds", 2'd2, 4'd3, 4'd0, 10'd101, 10'd100, 2'd1);
    op("bal3", 2'd1, 4'd3, 4'd0, 10'd0, 10'd100, 2'd0);
    chk("cnt_no_incr_err", 32'(bus.txn_count), cnt_exp());

    op("xfer1_4", 2'd3, 4'd1, 4'd4, 10'd60, 10'd40, 2'd0); exp_cnt++;
    op("bal4", 2'd1, 4'd4, 4'd0, 10'd0, 10'd160, 2'd0);
    op("xfer_same", 2'd3, 4'd4, 4'd4, 10'd10, 10'd160, 2'd3);
    op("exit", 2'd0, 4'd4, 4'd0, 10'd5, 10'd0, 2'd0);

    // Fill acct 7 to 1000 from accts 6 and 8..15
    for (int a = 6; a < 16; a++) begin
      if (a != 7) begin
        txn(2'd3, 4'(a), 4'd7, 10'd100, 1'b1, b, r, l);
        exp_cnt++;
      end
    end
    op("bal7_fill", 2'd1, 4'd7, 4'd0, 10'd0, 10'd1000, 2'd0);
    op("xfer_ovf", 2'd3, 4'd0, 4'd7, 10'd50, 10'd100, 2'd2);
    op("bal0_ovf", 2'd1, 4'd0, 4'd0, 10'd0, 10'd100, 2'd0);
    op("bal7_ovf", 2'd1, 4'd7, 4'd0, 10'd0, 10'd1000, 2'd0);
    op("xfer_funds_over_ovf", 2'd3, 4'd6, 4'd7, 10'd50, 10'd0, 2'd1);
    op("xfer_to_1023", 2'd3, 4'd0, 4'd7, 10'd23, 10'd77, 2'd0); exp_cnt++;
    op("bal7_1023", 2'd1, 4'd7, 4'd0, 10'd0, 10'd1023, 2'd0);
    op("xfer_ovf_by1", 2'd3, 4'd0, 4'd7, 10'd1, 10'd77, 2'd2);
    op("wdr_zero", 2'd2, 4'd5, 4'd0, 10'd0, 10'd100, 2'd0); exp_cnt++;
    op("wdr_all", 2'd2, 4'd5, 4'd0, 10'd100, 10'd0, 2'd0); exp_cnt++;
    chk("cnt_total", 32'(bus.txn_count), cnt_exp());

    // Response stall with requests pulsed meanwhile
    txn(2'd1, 4'd4, 4'd0, 10'd0, 1'b0, b, r, l);
    chk("stall_bal", 32'(b), 32'd160);
    for (int i = 0; i < 5; i++) begin
      bus.req_valid = (i % 2 == 0);
      bus.Select = 2'd2; bus.AccountNumber_s = 4'd4; bus.Amount = 10'd50;
      @(posedge clk); #1;
      chk("stall_valid", {31'd0, bus.resp_valid}, 32'd1);
      chk("stall_ready", {31'd0, bus.req_ready}, 32'd0);
      chk("stall_hold_bal", 32'(bus.Balance), 32'd160);
      chk("stall_hold_res", 32'(bus.result), 32'd0);
    end
    bus.req_valid = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("release_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("release_keep_bal", 32'(bus.Balance), 32'd160);
    op("bal4_ignored", 2'd1, 4'd4, 4'd0, 10'd0, 10'd160, 2'd0);

    // Reset while a withdraw sits in EXEC
    bus.Select = 2'd2; bus.AccountNumber_s = 4'd4; bus.Amount = 10'd10;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("midrst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("midrst_balance", 32'(bus.Balance), 32'd0);
    chk("midrst_txn_count", 32'(bus.txn_count), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp_cnt = 0;
    op("post_rst_bal4", 2'd1, 4'd4, 4'd0, 10'd0, 10'd100, 2'd0);
    op("post_rst_bal7", 2'd1, 4'd7, 4'd0, 10'd0, 10'd100, 2'd0);
    op("post_rst_bal5", 2'd1, 4'd5, 4'd0, 10'd0, 10'd100, 2'd0);
    chk("post_rst_cnt", 32'(bus.txn_count), cnt_exp());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
